// File: rtl/usb_tx_line_encoder.sv
// USB transmit line stage: bit stuffing, NRZI encoding and EOP generation
// driving the DP/DM pair from an LSB-first serial bit stream.
module usb_tx_line_encoder #(
    parameter int STUFF_LEN    = 6,
    parameter int SE0_CYCLES   = 2,
    parameter bit J_IS_DP_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst_L,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic pkt_end,
    output logic pause,
    output logic dp,
    output logic dm,
    output logic tx_en,
    output logic eop_done,
    output logic underrun
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] STUFF_MAX = CNT_W'(STUFF_LEN);
    localparam logic [1:0]       SE0_LAST  = 2'(SE0_CYCLES - 1);
    localparam logic LVL_J = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic             level_q, level_d;
    logic             end_lat_q, end_lat_d;
    logic [1:0]       se0_cnt_q, se0_cnt_d;
    logic             dp_q, dp_d;
    logic             dm_q, dm_d;
    logic             tx_en_q, tx_en_d;
    logic             eop_done_q, eop_done_d;
    logic             underrun_q, underrun_d;
    logic             j_sent_q, j_sent_d;

    logic             consume;
    logic             base_level;
    logic             next_level;
    logic [CNT_W-1:0] base_ones;
    logic [CNT_W-1:0] next_ones;

    // Line level 0 = J, 1 = K; mapped onto the wire pair by speed.
    function automatic logic [1:0] line_of(input logic lvl);
        logic d;
        d = J_IS_DP_HIGH ^ lvl;
        return {d, ~d};
    endfunction

    assign pause      = (state_q == ST_STUFF) || (state_q == ST_EOP_SE0) || (state_q == ST_EOP_J);
    assign consume    = bit_valid && ((state_q == ST_IDLE) || (state_q == ST_SEND));
    assign base_level = (state_q == ST_IDLE) ? LVL_J : level_q;
    assign base_ones  = (state_q == ST_IDLE) ? '0 : ones_cnt_q;
    assign next_ones  = bit_in ? base_ones + 1'b1 : '0;
    assign next_level = bit_in ? base_level : ~base_level;

    always_comb begin
        state_d    = state_q;
        ones_cnt_d = ones_cnt_q;
        level_d    = level_q;
        end_lat_d  = end_lat_q;
        se0_cnt_d  = se0_cnt_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        tx_en_d    = tx_en_q;
        underrun_d = 1'b0;
        j_sent_d   = (state_q == ST_EOP_J);
        eop_done_d = j_sent_q;

        case (state_q)
            ST_IDLE, ST_SEND: begin
                if (state_q == ST_IDLE) begin
                    {dp_d, dm_d} = line_of(LVL_J);
                    tx_en_d      = 1'b0;
                    level_d      = LVL_J;
                    ones_cnt_d   = '0;
                    end_lat_d    = 1'b0;
                end else begin
                    tx_en_d    = 1'b1;
                    underrun_d = !bit_valid;
                end
                if (consume) begin
                    ones_cnt_d   = next_ones;
                    level_d      = next_level;
                    {dp_d, dm_d} = line_of(next_level);
                    tx_en_d      = 1'b1;
                    se0_cnt_d    = '0;
                    // A stuff bit owed by the final data bit goes out before the EOP.
                    if (next_ones == STUFF_MAX) begin
                        state_d   = ST_STUFF;
                        end_lat_d = pkt_end;
                    end else if (pkt_end) begin
                        state_d = ST_EOP_SE0;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_STUFF: begin
                level_d      = ~level_q;
                ones_cnt_d   = '0;
                {dp_d, dm_d} = line_of(~level_q);
                tx_en_d      = 1'b1;
                se0_cnt_d    = '0;
                end_lat_d    = 1'b0;
                state_d      = end_lat_q ? ST_EOP_SE0 : ST_SEND;
            end
            ST_EOP_SE0: begin
                dp_d    = 1'b0;
                dm_d    = 1'b0;
                tx_en_d = 1'b1;
                if (se0_cnt_q == SE0_LAST) begin
                    state_d = ST_EOP_J;
                end else begin
                    se0_cnt_d = se0_cnt_q + 2'd1;
                end
            end
            ST_EOP_J: begin
                {dp_d, dm_d} = line_of(LVL_J);
                tx_en_d      = 1'b1;
                level_d      = LVL_J;
                ones_cnt_d   = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_L) begin
            state_q    <= ST_IDLE;
            ones_cnt_q <= '0;
            level_q    <= LVL_J;
            end_lat_q  <= 1'b0;
            se0_cnt_q  <= '0;
            dp_q       <= J_IS_DP_HIGH;
            dm_q       <= ~J_IS_DP_HIGH;
            tx_en_q    <= 1'b0;
            eop_done_q <= 1'b0;
            underrun_q <= 1'b0;
            j_sent_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_cnt_q <= ones_cnt_d;
            level_q    <= level_d;
            end_lat_q  <= end_lat_d;
            se0_cnt_q  <= se0_cnt_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            tx_en_q    <= tx_en_d;
            eop_done_q <= eop_done_d;
            underrun_q <= underrun_d;
            j_sent_q   <= j_sent_d;
        end
    end

    assign dp       = dp_q;
    assign dm       = dm_q;
    assign tx_en    = tx_en_q;
    assign eop_done = eop_done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench for usb_tx_line_encoder: directed and random packets
// compared cycle by cycle against an expected line timeline built from the bit rules.
module tb_usb_tx_line_encoder;

    localparam int MAXC = 4096;
    localparam int STUFF = 6;
    localparam int SE0N = 2;
    localparam int K_IDLE = 0, K_DATA = 1, K_HOLD = 2, K_STUFF = 3, K_SE0 = 4, K_EOPJ = 5;

    logic clk = 1'b0;
    logic rst_L = 1'b1;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic pkt_end = 1'b0;
    logic pause, dp, dm, tx_en, eop_done, underrun;

    int checks = 0;
    int failures = 0;

    usb_tx_line_encoder #(.STUFF_LEN(STUFF), .SE0_CYCLES(SE0N), .J_IS_DP_HIGH(1'b1)) dut (
        .clk(clk), .rst_L(rst_L), .bit_in(bit_in), .bit_valid(bit_valid), .pkt_end(pkt_end),
        .pause(pause), .dp(dp), .dm(dm), .tx_en(tx_en), .eop_done(eop_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Packet store
    logic bit_q[$];
    logic gap_q[$];
    int   pkt_base[$];
    int   pkt_len[$];
    int   pkt_start[$];

    // Expected line timeline, one entry per cycle
    logic e_dp[MAXC];
    logic e_dm[MAXC];
    logic e_en[MAXC];
    logic e_ur[MAXC];
    logic e_eop[MAXC];
    int   e_kind[MAXC];

    task automatic add_bit(input logic b, input logic g);
        bit_q.push_back(b);
        gap_q.push_back(g);
    endtask

    task automatic put_level(input int t, input logic lvl, input logic ur, input int kind);
        e_dp[t] = ~lvl;
        e_dm[t] = lvl;
        e_en[t] = 1'b1;
        e_ur[t] = ur;
        e_kind[t] = kind;
    endtask

    int total_cycles;

    task automatic build_model();
        int nf, s, t, ones, d;
        logic lvl, b;
        for (int i = 0; i < MAXC; i++) begin
            e_dp[i] = 1'b1; e_dm[i] = 1'b0; e_en[i] = 1'b0;
            e_ur[i] = 1'b0; e_eop[i] = 1'b0; e_kind[i] = K_IDLE;
        end
        nf = 0;
        for (int p = 0; p < pkt_len.size(); p++) begin
            d = (p == 0) ? 2 : ((p % 3 == 1) ? 0 : int'($urandom_range(0, 3)));
            s = nf + d;
            pkt_start.push_back(s);
            t = s + 1;
            lvl = 1'b0;
            ones = 0;
            for (int k = 0; k < pkt_len[p]; k++) begin
                b = bit_q[pkt_base[p] + k];
                if (k > 0 && gap_q[pkt_base[p] + k]) begin
                    put_level(t, lvl, 1'b1, K_HOLD);
                    t++;
                end
                if (!b) lvl = ~lvl;
                ones = b ? ones + 1 : 0;
                put_level(t, lvl, 1'b0, K_DATA);
                t++;
                if (ones == STUFF) begin
                    lvl = ~lvl;
                    ones = 0;
                    put_level(t, lvl, 1'b0, K_STUFF);
                    t++;
                end
            end
            for (int q = 0; q < SE0N; q++) begin
                e_dp[t] = 1'b0; e_dm[t] = 1'b0; e_en[t] = 1'b1; e_kind[t] = K_SE0;
                t++;
            end
            put_level(t, 1'b0, 1'b0, K_EOPJ);
            e_eop[t + 1] = 1'b1;
            nf = t;
        end
        total_cycles = nf + 4;
    endtask

    function automatic logic pause_exp(input int c);
        int k;
        k = e_kind[c + 1];
        return (k == K_STUFF) || (k == K_SE0) || (k == K_EOPJ);
    endfunction

    initial begin
        int pi, bi, k, npkt, len;
        logic gap_done, consumed, seen, b;

        // Directed packets: SYNC, stuff mid-packet, stuff on final bit, underrun gap
        pkt_base.push_back(bit_q.size());
        for (int i = 0; i < 8; i++) add_bit(i == 7, 1'b0);
        pkt_len.push_back(8);
        pkt_base.push_back(bit_q.size());
        add_bit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) add_bit(1'b1, 1'b0);
        add_bit(1'b0, 1'b0);
        pkt_len.push_back(9);
        pkt_base.push_back(bit_q.size());
        for (int i = 0; i < 6; i++) add_bit(1'b1, 1'b0);
        pkt_len.push_back(6);
        pkt_base.push_back(bit_q.size());
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b1, 1'b1); add_bit(1'b0, 1'b0);
        pkt_len.push_back(4);
        for (int p = 0; p < 10; p++) begin
            len = int'($urandom_range(1, 24));
            pkt_base.push_back(bit_q.size());
            for (int i = 0; i < len; i++) begin
                b = ($urandom_range(0, 3) != 0);
                add_bit(b, ($urandom_range(0, 7) == 0));
            end
            pkt_len.push_back(len);
        end
        npkt = pkt_len.size();
        build_model();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", 8'({dp, dm, tx_en, pause, underrun, eop_done}), 8'b100000);
        rst_L = 1'b0;
        @(posedge clk);

        pi = 0; bi = 0; gap_done = 1'b0;
        for (int c = 0; c < total_cycles; c++) begin
            @(negedge clk);
            check_eq("line", 8'({dp, dm, tx_en, pause, underrun, eop_done}),
                     8'({e_dp[c], e_dm[c], e_en[c], pause_exp(c), e_ur[c], e_eop[c]}));
            k = 0;
            if (pi < npkt && c >= pkt_start[pi]) begin
                k = bi - pkt_base[pi];
                if (k > 0 && gap_q[bi] && !gap_done && !pause) begin
                    bit_valid = 1'b0; pkt_end = 1'b0; gap_done = 1'b1;
                end else begin
                    bit_valid = 1'b1; bit_in = bit_q[bi]; pkt_end = (k == pkt_len[pi] - 1);
                end
            end else begin
                bit_valid = 1'b0; pkt_end = 1'b0;
            end
            consumed = bit_valid && !pause;
            @(posedge clk);
            if (consumed) begin
                bi++;
                gap_done = 1'b0;
                if (k == pkt_len[pi] - 1) begin
                    $display("pkt %0d len=%0d start=%0d sent", pi, pkt_len[pi], pkt_start[pi]);
                    pi++;
                end
            end
        end
        bit_valid = 1'b0; pkt_end = 1'b0;
        check_eq("bits_consumed", 8'(bi), 8'(bit_q.size()));

        // Reset while in STUFF
        @(negedge clk);
        bit_valid = 1'b1; bit_in = 1'b1; pkt_end = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (pause) seen = 1'b1;
        end
        check_eq("stuff_reached", 8'(seen), 8'd1);
        rst_L = 1'b1; bit_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_L = 1'b0;
        check_eq("rst_in_stuff", 8'({dp, dm, tx_en, pause, eop_done}), 8'b10000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("quiet_after_stuff_rst", 8'({tx_en, eop_done, underrun}), 8'd0);
        end
        $display("reset during STUFF done");

        // Reset while in EOP_SE0
        bit_valid = 1'b1; bit_in = 1'b0; pkt_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bit_valid = 1'b0; pkt_end = 1'b0;
        check_eq("se0_reached", 8'(pause), 8'd1);
        rst_L = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_L = 1'b0;
        check_eq("rst_in_se0", 8'({dp, dm, tx_en, pause, eop_done}), 8'b10000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("quiet_after_se0_rst", 8'({tx_en, eop_done, underrun}), 8'd0);
        end
        $display("reset during EOP_SE0 done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_encoder.md
Name: usb_tx_line_encoder

Overview:
- Final transmit stage of the USB host serial path.
- Consumes the LSB-first serial stream (SYNC, PID, payload, CRC) from the upstream shift/mux stage, one bit per clk.
- Applies bit stuffing, NRZI-encodes the stream, appends the EOP, and drives the DP/DM wire pair.
- Asserts pause toward the upstream stage whenever it cannot accept a bit.

Parameters:
- STUFF_LEN, 6: consecutive 1s that force an inserted 0.
- SE0_CYCLES, 2: EOP SE0 length in clk cycles (1..3).
- J_IS_DP_HIGH, 1: 1 = full-speed J (DP=1, DM=0); 0 = low-speed J (DP=0, DM=1).

Ports:
- clk  in  1  Single clock; one USB bit time per cycle.
- rst_L  in  1  Synchronous, active-high reset (asserted = 1). Name is kept per codebase convention.
- bit_in  in  1  Serial data bit, LSB-first.
- bit_valid  in  1  bit_in is valid this cycle.
- pkt_end  in  1  Qualifies the current valid bit as the last bit of the packet.
- pause  out  1  Encoder will not consume bit_in this cycle; upstream must hold bit_in, bit_valid and pkt_end.
- dp  out  1  D+ line level (registered).
- dm  out  1  D- line level (registered).
- tx_en  out  1  Wire driver enable (registered).
- eop_done  out  1  One-cycle pulse on the cycle after the EOP J cycle.
- underrun  out  1  One-cycle pulse when bit_valid=0 in SEND with no stuff pending.

Behaviour:
- Reset:
  - state=IDLE, ones_cnt=0, level=J.
  - dp/dm = J, tx_en=0, pause=0, eop_done=0, underrun=0.
  - Reset wins over every other event. Asserting reset mid-packet drops the packet with no EOP; outputs show reset values on the cycle after the reset edge.
- Consume rule: a bit is consumed at the edge where bit_valid=1, pause=0, and state is IDLE or SEND.
- Latency: dp/dm reflect the consumed bit in the cycle following that edge (1-cycle latency).
- NRZI: a 0 toggles the line level (J<->K); a 1 holds it. Level is J at the start of every packet.
- States:
  - IDLE: dp/dm=J, tx_en=0, pause=0. On consume -> SEND, tx_en=1 from the next cycle.
  - SEND: consume per the rule above.
    - ones_cnt increments on a 1 and clears on a 0.
    - When ones_cnt reaches STUFF_LEN: -> STUFF, and latch pkt_end if it was set.
    - Else if pkt_end: -> EOP_SE0.
    - If bit_valid=0: underrun pulse, level held, ones_cnt unchanged, stay in SEND.
  - STUFF: pause=1 for exactly one cycle; bit_in is ignored.
    - At the edge: emit 0 (level toggles), ones_cnt=0.
    - -> EOP_SE0 if pkt_end was latched, else -> SEND.
  - EOP_SE0: dp=dm=0 for SE0_CYCLES cycles, tx_en=1, pause=1 -> EOP_J.
  - EOP_J: dp/dm=J, tx_en=1, pause=1 for 1 cycle -> IDLE. eop_done=1 in the first IDLE cycle.
- pause is a function of registered state only (STUFF, EOP_SE0, EOP_J); it never depends combinationally on bit_in.
- Stuffing applies from the first SYNC bit through the last CRC bit, including a stuff bit triggered by the final data bit (it precedes the EOP).
- bit_valid=1 arriving in the eop_done cycle starts a new packet normally.

Test Plan:
1. SYNC 00000001 from reset idle: dp over 8 cycles = 0,1,0,1,0,1,0,0; dm = complement; tx_en=1 throughout; pause=0.
2. Send 0 then seven 1s (bit_valid held high), then 0 with pkt_end:
   - 0 drives K.
   - Six 1s hold K.
   - pause=1 for exactly one cycle; the stuff 0 drives J.
   - 7th 1 holds J; final 0 drives K.
   - EOP follows.
   - Total 10 line cycles before SE0.
3. Packet ends with six 1s, pkt_end on the 6th: one stuff-bit cycle (level toggles), then dp/dm = 00, 00, J; eop_done pulses 1 cycle later; tx_en=0 in the same cycle.
4. Upstream holds bit_in=1 and bit_valid through a pause cycle: the bit is consumed exactly once (checked against ones_cnt and line output); no bit is lost or duplicated.
5. Drop bit_valid for 1 cycle mid-SEND: underrun=1 for that cycle; dp/dm unchanged; the next valid bit encodes correctly.
6. Assert rst_L during EOP_SE0 and separately during STUFF: the next cycle shows dp/dm=J, tx_en=0, pause=0, with no eop_done pulse.
